// File: rtl/sync_fifo_ctrl_pkg.sv
// rtl/sync_fifo_ctrl_pkg.sv - shared sizing constants, status type and level helper for single-clock FIFOs
package sync_fifo_ctrl_pkg;

  // Supported address widths for the FIFO family.
  localparam int unsigned MIN_ADDRESS_SIZE = 2;
  localparam int unsigned MAX_ADDRESS_SIZE = 10;

  // Flags decoded from the registered pointers.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Number of storage words for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned address_size);
    return 32'd1 << address_size;
  endfunction

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned fifo_ptr_width(input int unsigned address_size);
    return address_size + 32'd1;
  endfunction

  // Occupancy from binary pointers, modulo 2**(address_size+1); yields depth when full.
  function automatic int unsigned fifo_level(input int unsigned w_ptr,
                                             input int unsigned r_ptr,
                                             input int unsigned address_size);
    int unsigned mask;
    mask = (32'd1 << fifo_ptr_width(address_size)) - 32'd1;
    return (w_ptr - r_ptr) & mask;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_regfile.sv
// rtl/sync_fifo_ctrl_regfile.sv - DATA_WIDTH x 2**ADDRESS_SIZE storage, sync write, registered read
module fifo_regfile
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en_i,
  input  logic [ADDRESS_SIZE-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic                    r_en_i,
  input  logic [ADDRESS_SIZE-1:0] r_addr_i,
  output logic [DATA_WIDTH-1:0]   r_data_o
);

  localparam int DEPTH = int'(fifo_depth(ADDRESS_SIZE));

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_q;

  // Storage array: written on accepted writes only, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_en_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  // Read register: loads on an accepted read, otherwise holds the last popped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
    end else if (r_en_i) begin
      r_data_q <= mem_q[r_addr_i];
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with level, almost flags and sticky error flags
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDRESS_SIZE        = 4,
  parameter int ALMOST_FULL_THRESH  = 2**ADDRESS_SIZE - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  w_full,
  output logic                  r_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDRESS_SIZE:0] level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = int'(fifo_depth(ADDRESS_SIZE));
  localparam int PTR_W = int'(fifo_ptr_width(ADDRESS_SIZE));

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] AF_THR  = PTR_W'(ALMOST_FULL_THRESH);
  localparam logic [PTR_W-1:0] AE_THR  = PTR_W'(ALMOST_EMPTY_THRESH);

  // Configuration sanity checks, caught at elaboration.
  if (ADDRESS_SIZE < int'(MIN_ADDRESS_SIZE) || ADDRESS_SIZE > int'(MAX_ADDRESS_SIZE)) begin : g_bad_addr
    $error("sync_fifo_ctrl: ADDRESS_SIZE out of range 2..10");
  end
  if (ALMOST_FULL_THRESH < 0 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_ctrl: ALMOST_FULL_THRESH outside 0..depth");
  end
  if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH) begin : g_bad_ae
    $error("sync_fifo_ctrl: ALMOST_EMPTY_THRESH outside 0..depth");
  end

  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic             r_valid_q, r_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [PTR_W-1:0] level_w;
  fifo_status_t     status;
  logic             write_ok;
  logic             read_ok;

  // Flags and level come only from the registered pointers, never from w_en/r_en.
  always_comb begin
    level_w             = PTR_W'(fifo_level(32'(w_ptr_q), 32'(r_ptr_q), ADDRESS_SIZE));
    status.full         = (w_ptr_q[PTR_W-1] != r_ptr_q[PTR_W-1]) &&
                          (w_ptr_q[ADDRESS_SIZE-1:0] == r_ptr_q[ADDRESS_SIZE-1:0]);
    status.empty        = (w_ptr_q == r_ptr_q);
    status.almost_full  = (level_w >= AF_THR);
    status.almost_empty = (level_w <= AE_THR);
  end

  assign write_ok = w_en & ~status.full;
  assign read_ok  = r_en & ~status.empty;

  // Next-state: pointer advance, read strobe and sticky errors where a new error beats clr_err.
  always_comb begin
    w_ptr_d     = write_ok ? (w_ptr_q + PTR_ONE) : w_ptr_q;
    r_ptr_d     = read_ok  ? (r_ptr_q + PTR_ONE) : r_ptr_q;
    r_valid_d   = read_ok;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (w_en && status.full) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
    if (r_en && status.empty) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end
  end

  // State registers; reset discards contents and masks any same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .w_en_i   (write_ok & ~rst),
    .w_addr_i (w_ptr_q[ADDRESS_SIZE-1:0]),
    .w_data_i (w_data),
    .r_en_i   (read_ok & ~rst),
    .r_addr_i (r_ptr_q[ADDRESS_SIZE-1:0]),
    .r_data_o (r_data)
  );

  assign r_valid      = r_valid_q;
  assign w_full       = status.full;
  assign r_empty      = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign level        = level_w;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
